// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0-T2), opcode decode, T3-T7 execute strobes.
// Optional CU_SINGLE_STEP_EN adds a `step` input and a PAUSE state between instructions.
module control_unit #(
  parameter logic [4:0] ADD_ENC = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout, IncPC, PCin,
  output logic        MARin, MDRin, MDRout, Read, ramWE,
  output logic        IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout,
  output logic        HIin, HIout, LOin, LOout, Cout, InPortout, OutPortIn, CONin,
  output logic        Gra, Grb, Grc, R_in, R_out, BAout,
  output logic [3:0]  tstate,
  output logic        run
);

  typedef enum logic [3:0] {
    RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
`ifdef CU_SINGLE_STEP_EN
    , PAUSE = 4'd10
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_t;

  localparam logic [5:0] ALU_LO = {1'b0, ADD_ENC};
  localparam logic [5:0] ALU_HI = ALU_LO + 6'd8;

  state_t      state, nxt, last, done;
  cls_t        cls;
  logic [4:0]  op;
  logic        unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign tstate    = state;

  always_comb begin
    cls = C_NOP;
    case (op)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b01100, 5'b01101, 5'b01110: cls = C_IMM;
      5'b01111, 5'b10000: cls = C_MULDIV;
      5'b10001, 5'b10010: cls = C_NEGNOT;
      5'b10011: cls = C_BR;
      5'b10100: cls = C_JR;
      5'b10110: cls = C_IN;
      5'b10111: cls = C_OUT;
      5'b11000: cls = C_MFHI;
      5'b11001: cls = C_MFLO;
      5'b11011: cls = C_HALT;
      default:  if ({1'b0, op} >= ALU_LO && {1'b0, op} <= ALU_HI) cls = C_ALU;
    endcase
  end

  // Final execute state of each class; stepping past it ends the instruction.
  always_comb begin
    last = T3;
    case (cls)
      C_NEGNOT:             last = T4;
      C_ALU, C_IMM, C_LDI:  last = T5;
      C_MULDIV, C_BR:       last = T6;
      C_LD, C_ST:           last = T7;
      default:              last = T3;
    endcase
`ifdef CU_SINGLE_STEP_EN
    done = (cls == C_HALT) ? HALT : PAUSE;
`else
    done = (cls == C_HALT) ? HALT : T0;
`endif
  end

  always_comb begin
    nxt = RST;
    case (state)
      RST:  nxt = T0;
      T0:   nxt = T1;
      T1:   nxt = T2;
      T2:   nxt = T3;
      T3:   nxt = (last == T3) ? done : T4;
      T4:   nxt = (last == T4) ? done : T5;
      T5:   nxt = (last == T5) ? done : T6;
      T6:   nxt = (last == T6) ? done : T7;
      T7:   nxt = done;
      HALT: nxt = HALT;
`ifdef CU_SINGLE_STEP_EN
      PAUSE: nxt = step ? T0 : PAUSE;
`endif
      default: nxt = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= RST;
    else     state <= nxt;
  end

  assign run = (state != RST) && (state != HALT)
`ifdef CU_SINGLE_STEP_EN
               && (state != PAUSE)
`endif
               ;

  always_comb begin
    {PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, ramWE} = '0;
    {IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout}         = '0;
    {HIin, HIout, LOin, LOout, Cout, InPortout, OutPortIn, CONin} = '0;
    {Gra, Grb, Grc, R_in, R_out, BAout}                     = '0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      T1: begin Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: case (cls)
        C_ALU, C_IMM:      begin Grb = 1'b1; R_out = 1'b1; Yin = 1'b1; end
        C_MULDIV:          begin Gra = 1'b1; R_out = 1'b1; Yin = 1'b1; end
        C_NEGNOT:          begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
        C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        C_BR:              begin Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; end
        C_JR:              begin Gra = 1'b1; R_out = 1'b1; PCin = 1'b1; end
        C_IN:              begin InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        C_OUT:             begin Gra = 1'b1; R_out = 1'b1; OutPortIn = 1'b1; end
        C_MFHI:            begin HIout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        C_MFLO:            begin LOout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        default: ;
      endcase
      T4: case (cls)
        C_ALU:                    begin Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; end
        C_IMM, C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZLowIn = 1'b1; end
        C_MULDIV: begin Grb = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1; end
        C_NEGNOT: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        C_BR:     begin PCout = 1'b1; Yin = 1'b1; end
        default: ;
      endcase
      T5: case (cls)
        C_ALU, C_IMM, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        C_MULDIV:            begin ZLowout = 1'b1; LOin = 1'b1; end
        C_LD, C_ST:          begin ZLowout = 1'b1; MARin = 1'b1; end
        C_BR:                begin Cout = 1'b1; ZLowIn = 1'b1; end
        default: ;
      endcase
      T6: case (cls)
        C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
        C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
        C_ST:     begin Gra = 1'b1; R_out = 1'b1; MDRin = 1'b1; end
        C_BR:     begin ZLowout = 1'b1; PCin = con_ff; end
        default: ;
      endcase
      T7: case (cls)
        C_LD:    begin MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1; end
        C_ST:    ramWE = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-opcode strobe-schedule model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, con_ff;
  logic [31:0] ir;
`ifdef CU_SINGLE_STEP_EN
  logic        step;
`endif
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, Read, ramWE;
  logic IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout;
  logic HIin, HIout, LOin, LOout, Cout, InPortout, OutPortIn, CONin;
  logic Gra, Grb, Grc, R_in, R_out, BAout;
  logic [3:0] tstate;
  logic run;

  control_unit #(.ADD_ENC(5'b00011)) dut (
    .clk(clk), .clr(clr),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .ramWE(ramWE),
    .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Cout(Cout),
    .InPortout(InPortout), .OutPortIn(OutPortIn), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BAout(BAout),
    .tstate(tstate), .run(run)
  );

  always #5 clk = ~clk;

  localparam logic [27:0] PCOUT = 28'd1 << 0,  INCPC = 28'd1 << 1,  PCIN   = 28'd1 << 2;
  localparam logic [27:0] MARIN = 28'd1 << 3,  MDRIN = 28'd1 << 4,  MDROUT = 28'd1 << 5;
  localparam logic [27:0] READ  = 28'd1 << 6,  RAMWE = 28'd1 << 7,  IRIN   = 28'd1 << 8;
  localparam logic [27:0] YIN   = 28'd1 << 9,  ZLIN  = 28'd1 << 10, ZHIN   = 28'd1 << 11;
  localparam logic [27:0] ZLOUT = 28'd1 << 12, ZHOUT = 28'd1 << 13, HIIN   = 28'd1 << 14;
  localparam logic [27:0] HIOUT = 28'd1 << 15, LOIN  = 28'd1 << 16, LOOUT  = 28'd1 << 17;
  localparam logic [27:0] COUT  = 28'd1 << 18, INPO  = 28'd1 << 19, OUTPI  = 28'd1 << 20;
  localparam logic [27:0] CONIN = 28'd1 << 21, GRA   = 28'd1 << 22, GRB    = 28'd1 << 23;
  localparam logic [27:0] GRC   = 28'd1 << 24, RIN   = 28'd1 << 25, ROUT   = 28'd1 << 26;
  localparam logic [27:0] BAOUT = 28'd1 << 27;

  logic [27:0] strobes;
  assign strobes = {BAout, R_out, R_in, Grc, Grb, Gra, CONin, OutPortIn, InPortout, Cout,
                    LOout, LOin, HIout, HIin, ZHighout, ZLowout, ZHighIn, ZLowIn, Yin, IRin,
                    ramWE, Read, MDRout, MDRin, MARin, PCin, IncPC, PCout};

  int unsigned checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef logic [27:0] vec_q[$];

  // Expected strobe set for every cycle of an instruction, fetch included.
  function automatic vec_q model_seq(input logic [4:0] op, input logic con);
    vec_q q;
    q = {};
    q.push_back(PCOUT | MARIN | INCPC);
    q.push_back(READ | MDRIN);
    q.push_back(MDROUT | IRIN);
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(GRB | ROUT | YIN); q.push_back(GRC | ROUT | ZLIN); q.push_back(ZLOUT | GRA | RIN);
    end else case (op)
      5'd12, 5'd13, 5'd14: begin
        q.push_back(GRB | ROUT | YIN); q.push_back(COUT | ZLIN); q.push_back(ZLOUT | GRA | RIN);
      end
      5'd15, 5'd16: begin
        q.push_back(GRA | ROUT | YIN); q.push_back(GRB | ROUT | ZLIN | ZHIN);
        q.push_back(ZLOUT | LOIN); q.push_back(ZHOUT | HIIN);
      end
      5'd17, 5'd18: begin q.push_back(GRB | ROUT | ZLIN); q.push_back(ZLOUT | GRA | RIN); end
      5'd0, 5'd2: begin
        q.push_back(GRB | BAOUT | YIN); q.push_back(COUT | ZLIN); q.push_back(ZLOUT | MARIN);
        if (op == 5'd0) begin q.push_back(READ | MDRIN); q.push_back(MDROUT | GRA | RIN); end
        else            begin q.push_back(GRA | ROUT | MDRIN); q.push_back(RAMWE); end
      end
      5'd1: begin
        q.push_back(GRB | BAOUT | YIN); q.push_back(COUT | ZLIN); q.push_back(ZLOUT | GRA | RIN);
      end
      5'd19: begin
        q.push_back(GRA | ROUT | CONIN); q.push_back(PCOUT | YIN); q.push_back(COUT | ZLIN);
        q.push_back(ZLOUT | (con ? PCIN : 28'd0));
      end
      5'd20: q.push_back(GRA | ROUT | PCIN);
      5'd22: q.push_back(INPO | GRA | RIN);
      5'd23: q.push_back(GRA | ROUT | OUTPI);
      5'd24: q.push_back(HIOUT | GRA | RIN);
      5'd25: q.push_back(LOOUT | GRA | RIN);
      default: q.push_back(28'd0);
    endcase
    return q;
  endfunction

  task automatic check_idle(input string tag, input int unsigned st);
    chk({tag, "_tstate"}, 32'(tstate), st);
    chk({tag, "_run"}, 32'(run), 0);
    chk({tag, "_strobes"}, 32'(strobes), 0);
  endtask

  // Entered at a falling edge with the DUT in T0; leaves with the DUT in T0 (or HALT).
  task automatic run_instr(input logic [31:0] iv, input logic c, input string name);
    vec_q q;
    q = model_seq(iv[31:27], c);
    ir = iv;
    con_ff = c;
    for (int i = 0; i < q.size(); i++) begin
`ifdef CU_SINGLE_STEP_EN
      step = 1'($urandom_range(0, 1));
`endif
      #1;
      chk({name, "_tstate"}, 32'(tstate), 32'(i + 1));
      chk({name, "_strobes"}, 32'(strobes), 32'(q[i]));
      chk({name, "_run"}, 32'(run), 1);
      @(negedge clk);
    end
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
    if (iv[31:27] != 5'd27) begin
      for (int k = 0; k < 3; k++) begin
        #1 check_idle({name, "_pause"}, 10);
        @(negedge clk);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
    end
`endif
  endtask

  initial begin
    vec_q q;
    logic [4:0] op;
    clr = 1'b1; ir = '0; con_ff = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1 check_idle("reset", 0);
    clr = 1'b0;
    @(negedge clk);

    // Reset asserted mid-instruction at T4 of an add.
    ir = 32'h1A9A0000;
    q = model_seq(5'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pre_rst_tstate", 32'(tstate), 32'(i + 1));
      chk("pre_rst_strobes", 32'(strobes), 32'(q[i]));
      if (i < 4) @(negedge clk);
    end
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check_idle("mid_rst", 0);
    end
    clr = 1'b0;
    @(negedge clk);

    run_instr(32'h1A9A0000, 1'b0, "add");
    run_instr(32'h01000055, 1'b0, "ld");
    run_instr(32'h98000000, 1'b1, "br_taken");
    run_instr(32'h98000000, 1'b0, "br_not");
    run_instr(32'h10000000, 1'b0, "st");
    run_instr(32'hD0000000, 1'b0, "nop");

    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), "rand");
    end

    run_instr(32'hD8000000, 1'b0, "halt");
    for (int k = 0; k < 20; k++) begin
      #1 check_idle("halt_hold", 9);
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    #1 check_idle("halt_clr", 0);
    clr = 1'b0;
    @(negedge clk);
    run_instr(32'h1A9A0000, 1'b0, "post_halt_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer that drives the CPU datapath's control strobes. It fetches each instruction (T0–T2), decodes the opcode from the IR, and steps through T3–T7 execution states, asserting datapath strobes one cycle at a time. Register selection (Gra/Grb/Grc), ALU operation and condition evaluation stay inside the datapath; this block only sequences them. It sits beside the datapath and drives every control input that is currently supplied by the testbench.

## Interface
Parameters:
- `ADD_ENC`, `5'b00011`, opcode of add. Opcodes `ADD_ENC`..`ADD_ENC+8` form the three-register ALU class.

Ports:
- `clk`  input  1  system clock, rising edge.
- `clr`  input  1  synchronous, active-high reset.
- `ir`  input  32  IR contents; opcode is `ir[31:27]`.
- `con_ff`  input  1  CON flip-flop output from the datapath.
- `PCout, IncPC, PCin`  output  1 each  PC strobes.
- `MARin, MDRin, MDRout, Read, ramWE`  output  1 each  memory-path strobes.
- `IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout`  output  1 each  IR/ALU strobes.
- `HIin, HIout, LOin, LOout, Cout, InPortout, OutPortIn, CONin`  output  1 each.
- `Gra, Grb, Grc, R_in, R_out, BAout`  output  1 each  select/encode strobes.
- `tstate`  output  4  current state code. RST=0, T0..T7=1..8, HALT=9, PAUSE=10.
- `run`  output  1  high except in RST, HALT and PAUSE.

## Operation
- Outputs are combinational decodes of the registered state and `ir[31:27]`. Every strobe not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: Read, MDRin.
  - T2: MDRout, IRin.
- Execute sequences. After the last listed step the next state is T0.
  - ALU reg (add..rol): T3 Grb R_out Yin; T4 Grc R_out ZLowIn; T5 ZLowout Gra R_in.
  - addi 01100, andi 01101, ori 01110: T3 Grb R_out Yin; T4 Cout ZLowIn; T5 ZLowout Gra R_in.
  - mul 01111, div 10000: T3 Gra R_out Yin; T4 Grb R_out ZLowIn ZHighIn; T5 ZLowout LOin; T6 ZHighout HIin.
  - neg 10001, not 10010: T3 Grb R_out ZLowIn; T4 ZLowout Gra R_in.
  - ld 00000: T3 Grb BAout Yin; T4 Cout ZLowIn; T5 ZLowout MARin; T6 Read MDRin; T7 MDRout Gra R_in.
  - ldi 00001: T3 Grb BAout Yin; T4 Cout ZLowIn; T5 ZLowout Gra R_in.
  - st 00010: T3–T5 as ld; T6 Gra R_out MDRin (Read=0); T7 ramWE.
  - branch 10011: T3 Gra R_out CONin; T4 PCout Yin; T5 Cout ZLowIn; T6 ZLowout, plus PCin only if `con_ff`=1.
  - jr 10100: T3 Gra R_out PCin.
  - in 10110: T3 InPortout Gra R_in.
  - out 10111: T3 Gra R_out OutPortIn.
  - mfhi 11000: T3 HIout Gra R_in.
  - mflo 11001: T3 LOout Gra R_in.
  - nop 11010, 10101, and any undefined opcode: T3 with no strobes.
  - halt 11011: T3 with no strobes, then HALT. HALT holds with all strobes 0 until `clr`.

## Timing
- `clr`=1 at a rising edge forces state RST. This applies mid-instruction too; no partial strobe survives. In RST all strobes are 0, `run`=0, `tstate`=0.
- RST always goes to T0 on the next edge once `clr`=0, so T0 is the first cycle after reset is released.
- The datapath samples each strobe on the rising edge that ends its state, giving one state per clock.
- Instruction length in cycles, counting fetch: ALU reg, immediate, ldi 6; mul/div 7; neg/not 5; ld/st 8; branch 7; single-step classes 4.
- `con_ff` is latched by the datapath at the end of T3. It is sampled combinationally during T6 and must stay stable there.
- `ir` is treated as stable from T3 through the last execute state.

## Configuration
- `CU_SINGLE_STEP_EN` defined:
  - Adds input `step` (1 bit).
  - After the final execute state, the FSM enters PAUSE instead of T0. All strobes are 0 and `run`=0 in PAUSE.
  - PAUSE goes to T0 on the first edge where `step`=1.
  - `step`=1 outside PAUSE is ignored.
  - `clr` overrides PAUSE.
- Undefined: no `step` port and no PAUSE state; the FSM goes directly to T0.

## Test plan
- Reset: hold `clr`=1 for 3 cycles in state T4, then release. Required: all strobes 0 and `tstate`=0 while `clr` is high; `tstate`=1 with PCout/MARin/IncPC=1 on the first cycle after release.
- add R5,R3,R4, `ir`=0x1A9A0000. Required: T3 Grb R_out Yin; T4 Grc R_out ZLowIn; T5 ZLowout Gra R_in; T0 again on cycle 7.
- ld R2,0x55(R0), `ir`=0x01000055. Required: T3 BAout=1, T6 Read MDRin, T7 MDRout Gra R_in; 8 cycles total.
- branch, `ir`=0x98000000:
  - `con_ff`=1: PCin=1 in T6.
  - `con_ff`=0: PCin=0 in T6.
  - Both cases return to T0 after T6.
- halt, `ir`=0xD8000000. Required: `tstate`=9 and `run`=0 for 20 cycles, then T0 after a 1-cycle `clr`.
- With `CU_SINGLE_STEP_EN`: after a nop, FSM holds `tstate`=10 until `step`=1, then `tstate`=1 on the next cycle.
